// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 keyboard definitions: prefixes, command keys,
// decoder state encoding and the command-key whitelist.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] KEY_F     = 8'h2B;
  localparam logic [7:0] KEY_H     = 8'h33;
  localparam logic [7:0] KEY_T     = 8'h2C;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } dec_state_t;

  function automatic logic is_cmd_key(input logic [7:0] c);
    return (c == KEY_F)     || (c == KEY_H)    ||
           (c == KEY_T)     || (c == KEY_UP)   ||
           (c == KEY_RIGHT) || (c == KEY_LEFT) ||
           (c == KEY_DOWN)  || (c == KEY_ESC);
  endfunction

endpackage

// File: rtl/ps2_key_event_ctrl_key_fifo.sv
// Show-ahead synchronous FIFO for key events.
// Head reads 0x00 while empty; a push when full needs a same-cycle pop.
module key_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [7:0]        din,
  input  logic              pop,
  output logic [7:0]        dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              pop_eff;
  logic              push_eff;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  assign dout     = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + ADDR_W'(1);
      unique case ({push_eff, pop_eff})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Scancode decoder keeping command-key releases, queued for the
// processor with a valid/ack handshake and receiver throttling.
module ps2_key_event_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_done_tick,
  input  logic [7:0]      rx_data,
  output logic            rx_en,
  input  logic            rd_ack,
  output logic [7:0]      key_code,
  output logic            key_valid,
  output logic [ADDR_W:0] fifo_count,
  output logic            overflow
);

  dec_state_t state;
  logic       is_brk;
  logic       is_ext;
  logic       in_brk;
  logic       push_req;
  logic       pop_req;
  logic       full;
  logic       empty;

  assign is_brk   = (rx_data == SC_BREAK);
  assign is_ext   = (rx_data == SC_EXT);
  assign in_brk   = (state == S_BRK) || (state == S_EXT_BRK);
  assign push_req = rx_done_tick && in_brk && is_cmd_key(rx_data);
  assign pop_req  = rd_ack && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else if (rx_done_tick) begin
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            is_brk:  state <= S_BRK;
            is_ext:  state <= S_EXT;
            default: state <= S_IDLE;
          endcase
        end
        S_EXT: begin
          unique case (1'b1)
            is_brk:  state <= S_EXT_BRK;
            is_ext:  state <= S_EXT;
            default: state <= S_IDLE;
          endcase
        end
        default: begin
          unique case (1'b1)
            is_ext:  state <= S_EXT;
            is_brk:  state <= state;
            default: state <= S_IDLE;
          endcase
        end
      endcase
    end
  end

  // Dropped only when full and no pop frees a slot this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_req && full && !pop_req) begin
      overflow <= 1'b1;
    end
  end

  key_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (rx_data),
    .pop   (pop_req),
    .dout  (key_code),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign key_valid = !empty;
  assign rx_en     = !full;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Scoreboard bench: expected key events are queued at stimulus time
// and checked by a monitor when the processor acknowledges them.
module tb_ps2_key_event_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en;
  logic       rd_ack = 1'b0;
  logic [7:0] key_code;
  logic       key_valid;
  logic [2:0] fifo_count;
  logic       overflow;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_key_event_ctrl #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rx_en        (rx_en),
    .rd_ack       (rd_ack),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  // Monitor: every accepted acknowledge consumes the head entry
  always @(negedge clk) begin
    if (!reset && rd_ack && key_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %02h, required no event", key_code);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        if (key_code !== e) begin
          errors++;
          $display("FAIL pop_code: got %02h, required %02h", key_code, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done_tick = 1'b1;
    rx_data      = b;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic send_ack(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done_tick = 1'b1;
    rx_data      = b;
    rd_ack       = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    rd_ack       = 1'b0;
  endtask

  task automatic ack();
    @(posedge clk); #1;
    rd_ack = 1'b1;
    @(posedge clk); #1;
    rd_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset with stray strobes that must be ignored
    @(posedge clk); #1;
    reset = 1'b1; rx_done_tick = 1'b1; rx_data = 8'hF0; rd_ack = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0; rd_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 8'h00);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rx_en", rx_en, 1);

    // Make is discarded, break is queued
    send(8'h2B);
    @(negedge clk);
    chk("make_no_event", key_valid, 0);
    send(8'hF0);
    exp_q.push_back(8'h2B);
    send(8'h2B);
    @(negedge clk);
    chk("brk_valid", key_valid, 1);
    chk("brk_code", key_code, 8'h2B);
    chk("brk_count", fifo_count, 1);
    ack();
    @(negedge clk);
    chk("ack_valid", key_valid, 0);

    // Extended make ignored, extended break queued, 0x1C rejected
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0);
    exp_q.push_back(8'h75);
    send(8'h75);
    send(8'hF0); send(8'h1C);
    @(negedge clk);
    chk("ext_count", fifo_count, 1);
    chk("ext_code", key_code, 8'h75);
    ack();
    @(negedge clk);
    chk("ext_drained", fifo_count, 0);

    // Fill to four, fifth is dropped
    send(8'hF0); exp_q.push_back(8'h2B); send(8'h2B);
    send(8'hF0); exp_q.push_back(8'h33); send(8'h33);
    send(8'hF0); exp_q.push_back(8'h2C); send(8'h2C);
    @(negedge clk);
    chk("three_rx_en", rx_en, 1);
    send(8'hF0); exp_q.push_back(8'h72); send(8'h72);
    @(negedge clk);
    chk("full_rx_en", rx_en, 0);
    chk("full_count", fifo_count, 4);
    chk("full_ovf_clear", overflow, 0);
    send(8'hF0); send(8'h76);
    @(negedge clk);
    chk("drop_ovf", overflow, 1);
    chk("drop_count", fifo_count, 4);
    chk("drop_head", key_code, 8'h2B);

    // Full with simultaneous pop and push of 0x6B
    send(8'hF0);
    exp_q.push_back(8'h6B);
    send_ack(8'h6B);
    @(negedge clk);
    chk("swap_count", fifo_count, 4);
    chk("swap_head", key_code, 8'h33);
    chk("swap_ovf", overflow, 1);
    repeat (4) ack();
    @(negedge clk);
    chk("drain_count", fifo_count, 0);
    chk("drain_rx_en", rx_en, 1);
    chk("drain_code", key_code, 8'h00);

    // Reset discards a pending break prefix
    send(8'hF0);
    do_reset();
    @(negedge clk);
    chk("rst2_ovf", overflow, 0);
    send(8'h2B);
    @(negedge clk);
    chk("rst2_no_event", fifo_count, 0);
    send(8'hF0);
    exp_q.push_back(8'h74);
    send(8'h74);
    @(negedge clk);
    chk("rst2_code", key_code, 8'h74);
    ack();

    // Acknowledge while empty changes nothing
    ack();
    @(negedge clk);
    chk("empty_ack_count", fifo_count, 0);
    chk("empty_ack_ovf", overflow, 0);
    chk("empty_ack_valid", key_valid, 0);

    // Push into empty with same-cycle ack keeps the entry
    send(8'hF0);
    exp_q.push_back(8'h33);
    send_ack(8'h33);
    @(negedge clk);
    chk("empty_push_count", fifo_count, 1);
    ack();

    // Repeated prefixes and a break-then-extend sequence
    send(8'hE0); send(8'hE0); send(8'hF0); send(8'hF0);
    exp_q.push_back(8'h6B);
    send(8'h6B);
    send(8'hF0); send(8'hE0); send(8'hF0);
    exp_q.push_back(8'h76);
    send(8'h76);
    @(negedge clk);
    chk("prefix_count", fifo_count, 2);
    ack(); ack();
    @(negedge clk);
    chk("final_count", fifo_count, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

Controller between the PS/2 frame receiver and the PicoBlaze port interface. Consumes raw scancode bytes, decodes make/break/extended prefixes, and keeps only release events of the eight command keys. It queues those events in a small FIFO and presents them to the processor with a valid/acknowledge handshake. It also throttles the receiver through `rx_en` when the queue is full.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.
- `ADDR_W`, 2: log2(`DEPTH`).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge.
- `rx_done_tick`  in  1  one-cycle strobe: `rx_data` holds a complete received byte.
- `rx_data`  in  8  received scancode byte; valid only with `rx_done_tick`.
- `rx_en`  out  1  receiver enable; high when the FIFO is not full.
- `rd_ack`  in  1  one-cycle strobe from the processor: current key consumed.
- `key_code`  out  8  scancode at the FIFO head; 0x00 when empty.
- `key_valid`  out  1  FIFO non-empty (processor's new-data flag).
- `fifo_count`  out  `ADDR_W`+1  number of queued events.
- `overflow`  out  1  sticky; set when an event is dropped because the FIFO is full.

## Operation
- Command whitelist: 0x2B F, 0x33 H, 0x2C T, 0x75 up, 0x74 right, 0x6B left, 0x72 down, 0x76 ESC.
- Decoder FSM states: `S_IDLE`, `S_BRK`, `S_EXT`, `S_EXT_BRK`. Transitions occur only on cycles with `rx_done_tick`=1.
  - `S_IDLE`:
    - 0xF0 → `S_BRK`.
    - 0xE0 → `S_EXT`.
    - Any other byte is a make or typematic repeat; discard it and stay in `S_IDLE`.
  - `S_EXT`:
    - 0xF0 → `S_EXT_BRK`.
    - 0xE0 → stay in `S_EXT`.
    - Any other byte is an extended make; discard it → `S_IDLE`.
  - `S_BRK` or `S_EXT_BRK`:
    - 0xE0 → `S_EXT`.
    - 0xF0 → stay in the current state.
    - Whitelisted code → push the code, then → `S_IDLE`.
    - Any other code → discard → `S_IDLE`.
- Extended and non-extended breaks of the same code are both pushed as the bare code. Example: E0 F0 75 pushes 0x75.
- FIFO is show-ahead:
  - `key_code` = entry at the read pointer.
  - `key_valid` = (`fifo_count` ≠ 0).
- `rd_ack` with `key_valid`=1 pops one entry. `rd_ack` with `key_valid`=0 is ignored.
- Push when full:
  - With no simultaneous pop, the event is dropped, `overflow` ← 1, and FIFO contents are unchanged.
  - With a simultaneous valid pop, the push is accepted.
- Push and pop in the same cycle on a non-empty FIFO: both take effect and `fifo_count` is unchanged.
- Push into an empty FIFO with `rd_ack` in the same cycle: the `rd_ack` is ignored and the entry is stored.
- `rx_en` = (`fifo_count` ≠ `DEPTH`).
  - The receiver may still finish a frame that started before `rx_en` fell.
  - Such an event follows the full rule above.
- Pointers wrap modulo `DEPTH`. `fifo_count` ranges 0..`DEPTH`.
- `overflow` clears only on `reset`.

## Timing
- Reset values:
  - FSM in `S_IDLE`, pointers 0.
  - `fifo_count`=0, `key_valid`=0, `key_code`=0x00, `overflow`=0, `rx_en`=1.
- Reset has priority over every other input. A `rx_done_tick` or `rd_ack` in a reset cycle is ignored.
- Reset mid-sequence (for example after 0xF0) discards the partial prefix. The next byte is decoded from `S_IDLE`.
- Push latency: the final byte's `rx_done_tick` arrives in cycle N. The entry is written at the end of N. If the FIFO was empty, `key_valid`=1 and `key_code` is valid in N+1.
- Pop latency: `rd_ack` in cycle N gives the new head (or `key_valid`=0) in N+1.
- `fifo_count`, `rx_en` and `overflow` update in the cycle after the causing event.
- All outputs are derived from registers. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `ps2_kbd_pkg` holds:
  - `SC_BREAK`=0xF0 and `SC_EXT`=0xE0.
  - The eight key-code constants.
  - The decoder state encoding (2-bit localparams).
  - An `is_cmd_key` function over the whitelist.
- Sub-module `key_fifo`: synchronous show-ahead FIFO with parameters `DEPTH` and `ADDR_W` and ports push/pop/full/empty/count.
- The top level contains the decoder FSM, the overflow flag and the `rx_en` logic.

## Test plan
- Send 0x2B, then F0 2B → no event after 0x2B. After 2B is received: `key_valid`=1, `key_code`=0x2B, `fifo_count`=1. `rd_ack` → `key_valid`=0 next cycle.
- Send E0 75, then E0 F0 75, then F0 1C → exactly one event, 0x75. 0x1C is not whitelisted and is discarded.
- With `DEPTH`=4, send five breaks (2B 33 2C 72 76) with no `rd_ack` → `rx_en`=0 after the fourth. The fifth is dropped and `overflow`=1. Four pops yield 2B, 33, 2C, 72 in order.
- FIFO full; `rd_ack` in the same cycle as a break of 0x6B → pop and push both happen. `fifo_count` stays 4 and the tail is 0x6B.
- Assert `reset` one cycle after F0, then send 0x2B → no event. A following F0 74 yields 0x74.
- `rd_ack` pulse while empty → no state change. `fifo_count`=0 and `overflow`=0.
